// File: rtl/axil_ctrl_slave.sv
// axil_ctrl_slave: AXI4-Lite responder exposing a bank of 32-bit control/status
// registers. AW and W may arrive in either order or together; writes commit one
// edge after both are captured; reads return registered data one edge after AR.
// Per-register wr_pulse/rd_pulse strobes let peripherals react to accesses.
//
// Build option: define AXIL_CTRL_WSTRB_EN to add control_wstrb and byte-lane
// writes. Without it every commit writes all four bytes.
//
// Handshake rule for every channel: a transfer happens on the rising clk edge
// where valid and ready are both high; a responder never drops valid or changes
// its payload before that edge, and ready depends only on registered state.
module axil_ctrl_slave #(
  parameter int                  ADDR_W   = 8,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      control_awaddr,
  input  logic                   control_awvalid,
  output logic                   control_awready,
  input  logic [31:0]            control_wdata,
`ifdef AXIL_CTRL_WSTRB_EN
  input  logic [3:0]             control_wstrb,
`endif
  input  logic                   control_wvalid,
  output logic                   control_wready,
  output logic [1:0]             control_bresp,
  output logic                   control_bvalid,
  input  logic                   control_bready,
  input  logic [ADDR_W-1:0]      control_araddr,
  input  logic                   control_arvalid,
  output logic                   control_arready,
  output logic [31:0]            control_rdata,
  output logic [1:0]             control_rresp,
  output logic                   control_rvalid,
  input  logic                   control_rready,
  output logic [NUM_REGS*32-1:0] reg_q,
  input  logic [NUM_REGS*32-1:0] ro_in,
  output logic [NUM_REGS-1:0]    wr_pulse,
  output logic [NUM_REGS-1:0]    rd_pulse
);

  localparam int         IDX_W     = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLV  = 2'b10;

  // Write-path state
  logic                   aw_full_q, aw_full_d;
  logic                   w_full_q, w_full_d;
  logic [IDX_W-1:0]       aw_idx_q, aw_idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS*32-1:0] regs_q, regs_d;
  logic [3:0]             byte_en;

`ifdef AXIL_CTRL_WSTRB_EN
  logic [3:0]             wstrb_q, wstrb_d;
`endif

  // Read-path state
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [NUM_REGS-1:0]    rd_pulse_q, rd_pulse_d;

  // Decode
  logic [NUM_REGS-1:0]    aw_hit, ar_hit;
  logic                   aw_ok, ar_ok;
  logic [31:0]            ar_data;
  logic                   aw_hs, w_hs, b_hs, commit, ar_hs, r_hs;

  // Byte-offset bits carry no meaning: accesses are always whole words.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{control_awaddr[1:0], control_araddr[1:0]};

  assign aw_hs  = control_awvalid && awready_q;
  assign w_hs   = control_wvalid && wready_q;
  assign b_hs   = bvalid_q && control_bready;
  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign ar_hs  = control_arvalid && arready_q;
  assign r_hs   = rvalid_q && control_rready;

`ifdef AXIL_CTRL_WSTRB_EN
  assign byte_en = wstrb_q;
`else
  assign byte_en = 4'hF;
`endif

  // Register index decode for the captured write and the live read address
  always_comb begin
    aw_hit  = '0;
    ar_hit  = '0;
    ar_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      aw_hit[i] = (aw_idx_q == IDX_W'(i));
      ar_hit[i] = (control_araddr[ADDR_W-1:2] == IDX_W'(i));
      if (ar_hit[i]) begin
        ar_data = RO_MASK[i] ? ro_in[32*i +: 32] : regs_q[32*i +: 32];
      end
    end
    // Out-of-range indices match no register; RO targets refuse writes.
    aw_ok = |(aw_hit & ~RO_MASK);
    ar_ok = |ar_hit;
  end

  // Write path: capture AW/W independently, commit once both are held
  always_comb begin
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
`ifdef AXIL_CTRL_WSTRB_EN
    wstrb_d    = wstrb_q;
`endif
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = control_awaddr[ADDR_W-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = control_wdata;
`ifdef AXIL_CTRL_WSTRB_EN
      wstrb_d  = control_wstrb;
`endif
    end
    // A commit cannot coincide with a new capture: both readies are low
    // while the flags are full.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok ? RESP_OKAY : RESP_SLV;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (aw_hit[i] && !RO_MASK[i] && (|byte_en)) begin
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
              regs_d[32*i + 8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
        end
      end
    end
    if (b_hs) begin
      bvalid_d = 1'b0;
    end
    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;
  end

  // Read path: one outstanding read, response held until accepted
  always_comb begin
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;
    if (ar_hs) begin
      rvalid_d   = 1'b1;
      rdata_d    = ar_data;
      rresp_d    = ar_ok ? RESP_OKAY : RESP_SLV;
      rd_pulse_d = ar_hit;
    end
    if (r_hs) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;
  end

  // Write-path registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      regs_q     <= '0;
`ifdef AXIL_CTRL_WSTRB_EN
      wstrb_q    <= '0;
`endif
    end else begin
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
`ifdef AXIL_CTRL_WSTRB_EN
      wstrb_q    <= wstrb_d;
`endif
    end
  end

  // Read-path registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rd_pulse_q <= '0;
    end else begin
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign control_awready = awready_q;
  assign control_wready  = wready_q;
  assign control_bvalid  = bvalid_q;
  assign control_bresp   = bresp_q;
  assign control_arready = arready_q;
  assign control_rvalid  = rvalid_q;
  assign control_rdata   = rdata_q;
  assign control_rresp   = rresp_q;
  assign reg_q           = regs_q;
  assign wr_pulse        = wr_pulse_q;
  assign rd_pulse        = rd_pulse_q;

endmodule
